// File: rtl/crc_frame_pkg.sv
// Shared types and CRC-8 arithmetic for the CRC frame protocol (transmit and checker sides).
package crc_frame_pkg;

  localparam int unsigned CRC_W = 8;
  localparam logic [CRC_W-1:0] CRC_POLY = 8'h07;
  localparam logic [CRC_W-1:0] CRC_INIT = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_CNT,
    ST_SEND_DATA,
    ST_SEND_CRC,
    ST_NOTIFY
  } state_e;

  // One byte into the register MSB-first, non-reflected.
  function automatic logic [CRC_W-1:0] crc8_next(input logic [CRC_W-1:0] crc,
                                                 input logic [CRC_W-1:0] data,
                                                 input logic [CRC_W-1:0] poly);
    logic [CRC_W-1:0] c;
    c = crc ^ data;
    for (int unsigned i = 0; i < CRC_W; i++) begin
      c = c[CRC_W-1] ? ((c << 1) ^ poly) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc_frame_tx_if.sv
// Request, payload, count, data and completion channels of the CRC frame transmitter.
interface crc_frame_tx_if #(
  parameter int unsigned WIDTH = 8
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_len;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             cnt_valid;
  logic             cnt_ready;
  logic [WIDTH-1:0] cnt_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             done_valid;
  logic             done_ready;
  logic             busy;

  modport master (
    input  req_valid, req_len, in_valid, in_data, cnt_ready, out_ready, done_ready,
    output req_ready, in_ready, cnt_valid, cnt_data, out_valid, out_data, done_valid, busy
  );

  modport slave (
    output req_valid, req_len, in_valid, in_data, cnt_ready, out_ready, done_ready,
    input  req_ready, in_ready, cnt_valid, cnt_data, out_valid, out_data, done_valid, busy
  );
endinterface

// File: rtl/crc_frame_tx_crc8_step.sv
// Combinational single-byte CRC-8 update.
module crc8_step
  import crc_frame_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLY = CRC_POLY
) (
  input  logic [CRC_W-1:0] crc_in,
  input  logic [CRC_W-1:0] data_in,
  output logic [CRC_W-1:0] crc_out
);
  assign crc_out = crc8_next(crc_in, data_in, POLY);
endmodule

// File: rtl/crc_frame_tx.sv
// Transmit end of the CRC frame protocol: count, payload bytes plus trailing CRC-8, then a done token.
module crc_frame_tx
  import crc_frame_pkg::*;
#(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = CRC_POLY,
  parameter logic [WIDTH-1:0] INIT  = CRC_INIT
) (
  input  logic          clk,
  input  logic          rst_n,
  crc_frame_tx_if.master bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] remaining_q, remaining_d;
  logic [WIDTH-1:0] crc_q, crc_d;
  logic [WIDTH-1:0] cnt_data_q, cnt_data_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             crc_loaded_q, crc_loaded_d;

  logic [WIDTH-1:0] crc_next;
  logic             slot_free;
  logic             req_ready, in_ready, cnt_valid, done_valid;

  crc8_step #(
    .POLY(POLY)
  ) u_crc8_step (
    .crc_in (crc_q),
    .data_in(bus.in_data),
    .crc_out(crc_next)
  );

  assign slot_free = !out_valid_q || bus.out_ready;

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    crc_d        = crc_q;
    cnt_data_d   = cnt_data_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    crc_loaded_d = crc_loaded_q;
    req_ready    = 1'b0;
    in_ready     = 1'b0;
    cnt_valid    = 1'b0;
    done_valid   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid) begin
          remaining_d  = bus.req_len;
          cnt_data_d   = bus.req_len;
          crc_d        = INIT;
          crc_loaded_d = 1'b0;
          state_d      = ST_SEND_CNT;
        end
      end
      ST_SEND_CNT: begin
        cnt_valid = 1'b1;
        if (bus.cnt_ready) begin
          state_d = (remaining_q != '0) ? ST_SEND_DATA : ST_SEND_CRC;
        end
      end
      ST_SEND_DATA: begin
        in_ready = (remaining_q != '0) && slot_free;
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
        end
        if (in_ready && bus.in_valid) begin
          out_data_d  = bus.in_data;
          out_valid_d = 1'b1;
          crc_d       = crc_next;
          remaining_d = remaining_q - WIDTH'(1);
          if (remaining_q == WIDTH'(1)) begin
            state_d = ST_SEND_CRC;
          end
        end
      end
      ST_SEND_CRC: begin
        // The last payload byte may still occupy the slot; the CRC replaces it as it drains.
        if (!crc_loaded_q) begin
          if (slot_free) begin
            out_data_d   = crc_q;
            out_valid_d  = 1'b1;
            crc_loaded_d = 1'b1;
          end
        end else if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_NOTIFY;
        end
      end
      ST_NOTIFY: begin
        done_valid = 1'b1;
        if (bus.done_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      remaining_q  <= '0;
      crc_q        <= INIT;
      cnt_data_q   <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      crc_loaded_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      crc_q        <= crc_d;
      cnt_data_q   <= cnt_data_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      crc_loaded_q <= crc_loaded_d;
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.in_ready   = in_ready;
  assign bus.cnt_valid  = cnt_valid;
  assign bus.cnt_data   = cnt_data_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.done_valid = done_valid;
  assign bus.busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_crc_frame_tx.sv
// Directed bench for crc_frame_tx with hand-computed CRC-8 (poly 0x07, init 0x00) expectations.
module tb_crc_frame_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  crc_frame_tx_if #(.WIDTH(8)) bus ();

  crc_frame_tx #(
    .WIDTH(8),
    .POLY (8'h07),
    .INIT (8'h00)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int vecs = 0;
  int fails = 0;
  int cyc = 0;
  bit rand_en = 1'b0;
  logic [7:0] got[$];
  int got_cyc[$];
  int done_cyc = -1;
  int in_ready_hits = 0;
  logic [7:0] q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Observes transfers at the clock edge, before any DUT state update lands.
  always @(posedge clk) begin
    if (bus.out_valid && bus.out_ready) begin
      got.push_back(bus.out_data);
      got_cyc.push_back(cyc);
    end
    if (bus.done_valid && bus.done_ready) done_cyc <= cyc;
    if (bus.in_ready) in_ready_hits <= in_ready_hits + 1;
    cyc <= cyc + 1;
  end

  always @(posedge clk) begin
    #1;
    bus.out_ready = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && !bus.out_ready) chk("in_ready_while_stalled", 32'(bus.in_ready), 32'd0);
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed still running, expected finished");
    $fatal(1, "watchdog");
  end

  function automatic logic sig(input int which);
    case (which)
      0:       return bus.req_ready;
      1:       return bus.in_ready;
      2:       return bus.done_valid;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_neg(input int which, input string tag);
    int n = 0;
    @(negedge clk);
    while (!sig(which) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!sig(which)) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic feed(input logic [7:0] data[$]);
    foreach (data[i]) begin
      bus.in_valid = 1'b1;
      bus.in_data  = data[i];
      wait_neg(1, "in_ready");
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] len, input logic [7:0] data[$],
                           input logic [7:0] exp_crc, input bit check_crc, input bit hold);
    int n;
    got.delete();
    got_cyc.delete();
    @(posedge clk);
    #1;
    in_ready_hits = 0;
    done_cyc = -1;
    bus.req_valid = 1'b1;
    bus.req_len   = len;
    if (hold) begin
      bus.cnt_ready  = 1'b0;
      bus.done_ready = 1'b0;
    end
    wait_neg(0, "req_ready");
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("cnt_valid_n1", 32'(bus.cnt_valid), 32'd1);
    chk("cnt_data", 32'(bus.cnt_data), 32'(len));
    if (hold) begin
      repeat (4) begin
        @(negedge clk);
        chk("cnt_valid_held", 32'(bus.cnt_valid), 32'd1);
        chk("cnt_data_held", 32'(bus.cnt_data), 32'(len));
        chk("req_ready_busy", 32'(bus.req_ready), 32'd0);
      end
      @(posedge clk);
      #1;
      bus.cnt_ready = 1'b1;
    end
    feed(data);
    wait_neg(2, "done_valid");
    if (hold) begin
      repeat (5) begin
        chk("done_valid_held", 32'(bus.done_valid), 32'd1);
        chk("req_ready_notify", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
      end
      @(posedge clk);
      #1;
      bus.done_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    chk("req_ready_after_done", 32'(bus.req_ready), 32'd1);
    chk("busy_after_done", 32'(bus.busy), 32'd0);
    n = got.size();
    chk("out_count", 32'(n), 32'(len) + 32'd1);
    if (n == int'(len) + 1) begin
      foreach (data[i]) chk($sformatf("payload[%0d]", i), 32'(got[i]), 32'(data[i]));
      if (check_crc) chk("crc_byte", 32'(got[len]), 32'(exp_crc));
      if (!rand_en && !hold) begin
        if (len != 0) chk("crc_follows_last", 32'(got_cyc[len] - got_cyc[len-1]), 32'd1);
        chk("done_follows_crc", 32'(done_cyc - got_cyc[len]), 32'd1);
      end
    end
    if (len == 0) chk("no_in_ready_len0", 32'(in_ready_hits), 32'd0);
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_len    = '0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.cnt_ready  = 1'b1;
    bus.done_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_cnt_valid", 32'(bus.cnt_valid), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_done_valid", 32'(bus.done_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_cnt_data", 32'(bus.cnt_data), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    rst_n = 1'b1;

    q = {};
    run_frame(8'd0, q, 8'h00, 1'b1, 1'b0);

    q = {8'h01};
    run_frame(8'd1, q, 8'h07, 1'b1, 1'b0);

    q = {8'h01, 8'h02};
    run_frame(8'd2, q, 8'h1B, 1'b1, 1'b0);

    rand_en = 1'b1;
    q = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    run_frame(8'd9, q, 8'hF4, 1'b1, 1'b0);
    rand_en = 1'b0;

    q = {8'h02};
    run_frame(8'd1, q, 8'h0E, 1'b1, 1'b1);

    q = {};
    for (int i = 0; i < 255; i++) q.push_back(8'(i * 7 + 3));
    run_frame(8'd255, q, 8'h00, 1'b0, 1'b0);

    // Abandon a 5-byte frame after its third byte.
    @(posedge clk);
    #1;
    bus.req_valid = 1'b1;
    bus.req_len   = 8'd5;
    wait_neg(0, "req_ready_rst");
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    q = {8'hA1, 8'hB2, 8'hC3};
    feed(q);
    rst_n = 1'b0;
    #1;
    chk("midrst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("midrst_cnt_valid", 32'(bus.cnt_valid), 32'd0);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_done_valid", 32'(bus.done_valid), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_cnt_data", 32'(bus.cnt_data), 32'd0);
    chk("midrst_out_data", 32'(bus.out_data), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    q = {8'h01};
    run_frame(8'd1, q, 8'h07, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule

// File: doc/crc_frame_tx.md
# crc_frame_tx

Transmit end of the CRC frame protocol. Takes a frame request (byte count) and a payload byte stream, and drives three outbound channels. The count channel gets the byte count. The data channel gets the payload bytes followed by one CRC-8 byte. The notification channel gets a completion token. Sits upstream of the CRC checker, so the checker's count/data ordering and its single trailing compare byte are met exactly.

## Interface
- `WIDTH`, 8: payload, count and CRC width.
- `POLY`, 8'h07: CRC-8 generator polynomial, MSB-first, no reflection.
- `INIT`, 8'h00: CRC register value at the start of each frame.

- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `req_valid` in 1 / `req_ready` out 1 / `req_len` in WIDTH: frame request; `req_len` is the number of payload bytes.
- `in_valid` in 1 / `in_ready` out 1 / `in_data` in WIDTH: payload byte stream.
- `cnt_valid` out 1 / `cnt_ready` in 1 / `cnt_data` out WIDTH: count channel.
- `out_valid` out 1 / `out_ready` in 1 / `out_data` out WIDTH: data channel, carrying payload then CRC.
- `done_valid` out 1 / `done_ready` in 1: completion notification.
- `busy` out 1: high in every state except IDLE.

## Operation
- All channels use the valid/ready rule:
  - Transfer happens on a cycle where valid and ready are both high.
  - Once valid is raised, it and its data stay stable until the transfer.
  - Valid never depends combinationally on ready.
- State machine: IDLE, SEND_CNT, SEND_DATA, SEND_CRC, NOTIFY.
- **IDLE**
  - `req_ready`=1.
  - On request transfer: latch `req_len` into `remaining` and `cnt_data`, set crc=`INIT`, go to SEND_CNT.
- **SEND_CNT**
  - `cnt_valid`=1.
  - On transfer: go to SEND_DATA if `remaining`≠0, otherwise SEND_CRC.
- **SEND_DATA**
  - `in_ready` = (`remaining`≠0) && (!`out_valid` || `out_ready`).
  - On input transfer: `out_data`←`in_data`, `out_valid`←1, crc←crc8_step(crc, `in_data`), `remaining`−1.
  - Go to SEND_CRC on the transfer where `remaining` goes 1→0.
- **SEND_CRC**
  - When the output slot is free (!`out_valid` || `out_ready`): load `out_data`←crc and `out_valid`←1. This happens once per frame.
  - When the CRC byte transfers, go to NOTIFY.
- **NOTIFY**
  - `done_valid`=1.
  - On transfer: go to IDLE.
- crc8_step:
  - Shift in 8 bits MSB-first: xor the byte into the register.
  - Then 8 iterations of: shift left; if the bit shifted out was 1, xor `POLY`.
  - All arithmetic is modulo 2^WIDTH; `remaining` never underflows.
- `req_len`=0: frame is count, then a CRC byte equal to `INIT`, then done. No `in_ready` assertion at all.
- `req_len`=255: 255 payload bytes, no wrap.
- Input arriving outside SEND_DATA is not accepted (`in_ready`=0). A new request is not accepted until NOTIFY completes.
- `out_ready` low stalls the stream: `in_ready` drops while the slot is full, and no bytes are dropped or duplicated.
- Reset asserted mid-frame abandons the frame. The next frame starts clean.

## Timing
- Reset values:
  - State=IDLE, `remaining`=0, crc=`INIT`.
  - `req_ready`=1.
  - `in_ready`, `cnt_valid`, `out_valid`, `done_valid`, `busy` = 0.
  - `cnt_data`, `out_data` = 0.
- Request transfer at cycle N → `cnt_valid`=1 at N+1.
- Input transfer at cycle k → byte on `out_data` with `out_valid` at k+1 (1-cycle latency).
- With `out_ready` held high: one payload byte per cycle. The CRC byte is valid the cycle after the last payload byte is valid.
- CRC byte transfer at cycle m → `done_valid` at m+1.
- Done transfer at cycle d → `req_ready`=1 at d+1.

## Structure
- Package `crc_frame_pkg`:
  - State enum.
  - `CRC_POLY`, `CRC_INIT` constants.
  - Function `crc8_next`, shared with the checker-side model.
- Sub-module `crc8_step`: combinational one-byte CRC update, instantiated once. All sequential logic lives in `crc_frame_tx`.

## Test plan
- `req_len`=0, all readies high → `cnt_data`=0x00, one data byte 0x00, then `done_valid`. `in_ready` never high.
- `req_len`=1, byte 0x01 → data channel 0x01 then CRC 0x07.
- `req_len`=2, bytes 0x01, 0x02 → 0x01, 0x02, then CRC 0x1B.
- `req_len`=9, ASCII "123456789", `out_ready` toggling randomly → bytes unchanged and in order, CRC 0xF4, `in_ready` low whenever the slot is full and unready.
- `cnt_ready` and `done_ready` held low 5 cycles each → valid and data stay stable, no request accepted until done transfers.
- Assert `rst_n` low after byte 3 of a 5-byte frame → all outputs return to reset values immediately. A following `req_len`=1 frame with byte 0x01 then yields CRC 0x07.
